// File: rtl/sfsram_osc_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sfsram_osc_mon_pkg
//  Brief    : Shared state encoding and default constants for the oscillator
//             health monitor.
//  Revision : 1.0 - initial release
// ============================================================================
package sfsram_osc_mon_pkg;

  // Monitor FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_STUCK   = 2'd3
  } mon_state_e;

  // Default configuration
  localparam int unsigned DEF_WINDOW_EDGES = 16;
  localparam int unsigned DEF_CNT_W        = 24;
  localparam int unsigned DEF_MIN_CYCLES   = 720;
  localparam int unsigned DEF_MAX_CYCLES   = 880;
  localparam int unsigned DEF_STUCK_CYCLES = 200;
  localparam int unsigned DEF_ERR_W        = 8;

endpackage
`default_nettype wire

// File: rtl/sfsram_osc_mon_sync.sv
`default_nettype none
// ============================================================================
//  Module   : sfsram_osc_mon_sync
//  Brief    : Two-flop synchronizer for the asynchronous oscillator input
//             followed by a rising-edge detector producing a one-cycle pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module sfsram_osc_mon_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Shift the raw input through the synchronizer and edge-history flop
  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchronizer and edge-history registers, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/sfsram_osc_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : sfsram_osc_monitor
//  Brief    : Measures an on-chip oscillator period against the fabric clock
//             over back-to-back windows of rising edges; reports the count,
//             an in-range flag, a stuck flag and a saturating error count.
//  Revision : 1.0 - initial release
// ============================================================================
module sfsram_osc_monitor
  import sfsram_osc_mon_pkg::*;
#(
  parameter int unsigned WINDOW_EDGES = DEF_WINDOW_EDGES,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned MIN_CYCLES   = DEF_MIN_CYCLES,
  parameter int unsigned MAX_CYCLES   = DEF_MAX_CYCLES,
  parameter int unsigned STUCK_CYCLES = DEF_STUCK_CYCLES,
  parameter int unsigned ERR_W        = DEF_ERR_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             OSC_IN,
  output logic [CNT_W-1:0] PERIOD_COUNT,
  output logic             COUNT_VALID,
  output logic             FREQ_OK,
  output logic             OSC_STUCK,
  output logic [ERR_W-1:0] ERR_COUNT
);

  localparam int unsigned EDGE_W = $clog2(WINDOW_EDGES + 1);
  localparam int unsigned TMR_W  = $clog2(STUCK_CYCLES + 1);

  logic edge_pulse;

  sfsram_osc_mon_sync u_sync (
    .clk  (CLK),
    .rst  (RESET),
    .d_in (OSC_IN),
    .rise (edge_pulse)
  );

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [EDGE_W-1:0] edges_q, edges_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             freq_ok_q, freq_ok_d;
  logic             stuck_q, stuck_d;
  logic [ERR_W-1:0] err_q, err_d;

  // Saturating increments, window-close and stuck-timeout conditions.
  // cyc_inc is also the elapsed count at a closing edge, since the
  // counter starts from zero in the cycle after the opening edge.
  logic [CNT_W-1:0] cyc_inc;
  logic [ERR_W-1:0] err_inc;
  logic             in_range;
  logic             last_edge;
  logic             timer_expire;

  // Derive saturating increments and compare results
  always_comb begin
    cyc_inc      = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;
    err_inc      = (err_q == '1) ? err_q : err_q + 1'b1;
    in_range     = (cyc_inc != '1) &&
                   (cyc_inc >= CNT_W'(MIN_CYCLES)) &&
                   (cyc_inc <= CNT_W'(MAX_CYCLES));
    last_edge    = (edges_q == EDGE_W'(WINDOW_EDGES - 1));
    // Timer reaches STUCK_CYCLES on this cycle if no edge arrives
    timer_expire = (timer_q == TMR_W'(STUCK_CYCLES - 1));
  end

  // Next-state and output logic; ENABLE low overrides every state
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    edges_d   = edges_q;
    timer_d   = timer_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    freq_ok_d = freq_ok_q;
    stuck_d   = stuck_q;
    err_d     = err_q;
    if (!ENABLE) begin
      state_d   = ST_IDLE;
      cyc_d     = '0;
      edges_d   = '0;
      timer_d   = '0;
      freq_ok_d = 1'b0;
      stuck_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cyc_d   = '0;
          edges_d = '0;
          timer_d = '0;
          state_d = ST_ARM;
        end
        ST_ARM, ST_MEASURE: begin
          if (state_q == ST_MEASURE) cyc_d = cyc_inc;
          if (edge_pulse) begin
            // An edge always wins over a simultaneous stuck timeout
            timer_d = '0;
            if (state_q == ST_MEASURE && last_edge) begin
              period_d  = cyc_inc;
              valid_d   = 1'b1;
              freq_ok_d = in_range;
              if (!in_range) err_d = err_inc;
            end
            if (state_q == ST_MEASURE && !last_edge) begin
              edges_d = edges_q + 1'b1;
            end else begin
              // Opening (or closing-and-reopening) edge starts a new window
              cyc_d   = '0;
              edges_d = '0;
            end
            state_d = ST_MEASURE;
          end else if (timer_expire) begin
            state_d   = ST_STUCK;
            stuck_d   = 1'b1;
            freq_ok_d = 1'b0;
            err_d     = err_inc;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_STUCK: begin
          if (edge_pulse) begin
            stuck_d = 1'b0;
            cyc_d   = '0;
            edges_d = '0;
            timer_d = '0;
            state_d = ST_MEASURE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, counter and output registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cyc_q     <= '0;
      edges_q   <= '0;
      timer_q   <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      freq_ok_q <= 1'b0;
      stuck_q   <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      edges_q   <= edges_d;
      timer_q   <= timer_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      freq_ok_q <= freq_ok_d;
      stuck_q   <= stuck_d;
      err_q     <= err_d;
    end
  end

  assign PERIOD_COUNT = period_q;
  assign COUNT_VALID  = valid_q;
  assign FREQ_OK      = freq_ok_q;
  assign OSC_STUCK    = stuck_q;
  assign ERR_COUNT    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sfsram_osc_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sfsram_osc_monitor
//  Brief    : Self-checking bench for sfsram_osc_monitor. A reference model
//             built on event times (window start, last edge) predicts every
//             output each cycle; directed checks cover the headline cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sfsram_osc_monitor;

  localparam int WIN   = 16;
  localparam int MINC  = 720;
  localparam int MAXC  = 880;
  localparam int STK   = 200;
  localparam int ERRMX = 255;
  localparam int CNTMX = (1 << 24) - 1;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        osc_in;
  logic [23:0] period_count;
  logic        count_valid;
  logic        freq_ok;
  logic        osc_stuck;
  logic [7:0]  err_count;

  sfsram_osc_monitor dut (
    .CLK          (clk),
    .RESET        (rst),
    .ENABLE       (enable),
    .OSC_IN       (osc_in),
    .PERIOD_COUNT (period_count),
    .COUNT_VALID  (count_valid),
    .FREQ_OK      (freq_ok),
    .OSC_STUCK    (osc_stuck),
    .ERR_COUNT    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int n       = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  // ---------------- oscillator generator ----------------
  int osc_per = 0;
  int phase   = 0;
  initial begin
    osc_in = 1'b0;
    forever begin
      @(negedge clk);
      if (osc_per < 2) begin
        phase  = 0;
        osc_in = 1'b0;
      end else begin
        if (phase >= osc_per) phase = 0;
        osc_in = (phase < osc_per / 2);
        phase  = (phase + 1) % osc_per;
      end
    end
  end

  // ---------------- reference model ----------------
  localparam int MD_OFF = 0, MD_WAIT = 1, MD_MEAS = 2, MD_STUCK = 3;
  int  m_mode;
  int  win_start;    // cycle at which the current window opened
  int  last_evt;     // cycle of last edge (or arming) for the stuck rule
  int  m_edges;      // edges seen since the window opened
  bit  seen [0:2];   // oscillator level sampled 1, 2, 3 cycles ago
  int  e_period, e_err;
  bit  e_valid, e_fok, e_stuck;

  task automatic model_reset();
    m_mode = MD_OFF; win_start = 0; last_evt = 0; m_edges = 0;
    seen[0] = 0; seen[1] = 0; seen[2] = 0;
    e_period = 0; e_err = 0; e_valid = 0; e_fok = 0; e_stuck = 0;
  endtask

  task automatic err_bump();
    if (e_err < ERRMX) e_err++;
  endtask

  // An oscillator rise acts on the monitor two clock edges after it is sampled
  task automatic model_step(input bit en, input bit osc);
    bit ev;
    int span;
    ev = seen[1] && !seen[2];
    seen[2] = seen[1]; seen[1] = seen[0]; seen[0] = osc;
    e_valid = 0;
    if (!en) begin
      m_mode = MD_OFF; e_fok = 0; e_stuck = 0;
    end else if (m_mode == MD_OFF) begin
      m_mode = MD_WAIT; last_evt = n;
    end else if (m_mode == MD_STUCK) begin
      if (ev) begin
        e_stuck = 0; m_mode = MD_MEAS; win_start = n; m_edges = 0; last_evt = n;
      end
    end else if (ev) begin
      if (m_mode == MD_MEAS && m_edges + 1 == WIN) begin
        span = n - win_start;
        if (span > CNTMX) span = CNTMX;
        e_period = span;
        e_valid  = 1;
        e_fok    = (span >= MINC) && (span <= MAXC) && (span != CNTMX);
        if (!e_fok) err_bump();
      end
      if (m_mode == MD_MEAS && m_edges + 1 < WIN) m_edges++;
      else begin win_start = n; m_edges = 0; end
      m_mode = MD_MEAS; last_evt = n;
    end else if (n - last_evt >= STK) begin
      m_mode = MD_STUCK; e_stuck = 1; e_fok = 0; err_bump();
    end
  endtask

  // Model advance and full output comparison on every cycle
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      n++;
      if (rst) model_reset();
      else     model_step(enable, osc_in);
      #1;
      check("count_valid",  {31'd0, count_valid}, {31'd0, e_valid});
      check("period_count", {8'd0, period_count},  e_period);
      check("freq_ok",      {31'd0, freq_ok},      {31'd0, e_fok});
      check("osc_stuck",    {31'd0, osc_stuck},    {31'd0, e_stuck});
      check("err_count",    {24'd0, err_count},    e_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic run(input int per, input int cycles);
    osc_per = per;
    repeat (cycles) @(negedge clk);
  endtask

  function automatic int pick_period();
    int unsigned s;
    s = $urandom_range(0, 5);
    case (s)
      0: return 50;
      1: return 44;
      2: return 60;
      3: return 46;
      4: return 55;
      default: return int'($urandom_range(30, 70));
    endcase
  endfunction

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_period", {8'd0, period_count}, 0);
    check("rst_valid",  {31'd0, count_valid}, 0);
    check("rst_freq",   {31'd0, freq_ok}, 0);
    check("rst_stuck",  {31'd0, osc_stuck}, 0);
    check("rst_err",    {24'd0, err_count}, 0);
    rst    = 1'b0;
    enable = 1'b1;

    // In-range clock
    run(50, 2600);
    check("inrange_period", {8'd0, period_count}, 800);
    check("inrange_freq",   {31'd0, freq_ok}, 1);
    check("inrange_err",    {24'd0, err_count}, 0);

    // Slow then fast out-of-range clocks
    run(60, 3200);
    check("slow_period", {8'd0, period_count}, 960);
    check("slow_freq",   {31'd0, freq_ok}, 0);
    run(44, 2200);
    check("fast_period", {8'd0, period_count}, 704);
    check("fast_freq",   {31'd0, freq_ok}, 0);

    // Stuck oscillator, then recovery
    run(0, 400);
    check("stuck_flag", {31'd0, osc_stuck}, 1);
    check("stuck_freq", {31'd0, freq_ok}, 0);
    run(50, 1800);
    check("recover_flag",   {31'd0, osc_stuck}, 0);
    check("recover_period", {8'd0, period_count}, 800);

    // ENABLE drop mid-window
    run(50, 420);
    enable = 1'b0;
    run(50, 20);
    check("endrop_freq",   {31'd0, freq_ok}, 0);
    check("endrop_period", {8'd0, period_count}, 800);
    enable = 1'b1;
    run(50, 1800);
    check("reenable_period", {8'd0, period_count}, 800);

    // Randomized segments
    for (int s = 0; s < 24; s++) begin
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel < 2) begin
        run(0, int'($urandom_range(150, 400)));
      end else if (sel < 4) begin
        run(pick_period(), int'($urandom_range(50, 900)));
        enable = 1'b0;
        run(osc_per, int'($urandom_range(1, 30)));
        enable = 1'b1;
      end else begin
        run(pick_period(), int'($urandom_range(300, 1800)));
      end
    end

    // Asynchronous reset mid-window
    run(50, 1700);
    run(50, 300);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_period", {8'd0, period_count}, 0);
    check("async_freq",   {31'd0, freq_ok}, 0);
    check("async_err",    {24'd0, err_count}, 0);
    check("async_stuck",  {31'd0, osc_stuck}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Error counter saturation with many short windows
    run(4, 310 * 64 + 100);
    check("sat_err",    {24'd0, err_count}, 255);
    check("sat_period", {8'd0, period_count}, 64);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
